// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with flush-to-bubble and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to build the 2-entry skid version with a registered in_ready.
module pipe_stage_buf #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] BUBBLE_DATA = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign pop_s     = out_valid && out_ready;
    assign push_s    = in_valid && in_ready && !flush;
    assign stall_cnt = stall_cnt_q;

    // Stall counter next state: saturates, and flush deliberately leaves it alone
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;
    logic             in_ready_q;
    logic             in_ready_d;

    // Occupancy FSM; main always holds the head so out_data needs no mux
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = BUBBLE_DATA;
            skid_data_d = BUBBLE_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && !pop_s) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                    end else if (pop_s && !push_s) begin
                        state_d     = ST_EMPTY;
                        main_data_d = BUBBLE_DATA;
                    end else if (push_s && pop_s) begin
                        main_data_d = in_data;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        skid_data_d = BUBBLE_DATA;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = BUBBLE_DATA;
                    skid_data_d = BUBBLE_DATA;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // State and payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= BUBBLE_DATA;
            skid_data_q <= BUBBLE_DATA;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
`else
    logic             main_valid_q;
    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;

    // Single entry; data returns to bubble whenever the entry empties
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_DATA;
        end else if (push_s) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (pop_s) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_DATA;
        end else begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
        end
    end

    // Main entry registers
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE_DATA;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    assign in_ready  = !main_valid_q || out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: table vectors, directed corner cases and a
// queue-based reference model under random stimulus. Works for either build.
module tb_pipe_stage_buf;

    localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;
    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_data;
    logic [2:0]  sat_stall_cnt;

    pipe_stage_buf #(.WIDTH(32), .BUBBLE_DATA(BUB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.WIDTH(32), .BUBBLE_DATA(BUB), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .stall_cnt(sat_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a FIFO of capacity 1 or 2 plus a stall tally
    logic [31:0] mq[$];
    logic [31:0] obs[$];
    int unsigned m_cnt = 0;
    bit          m_known = 1'b0;
    bit          cur_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input bit ordy);
        if (SKID) return (mq.size() < 2);
        return (mq.size() == 0) || ordy;
    endfunction

    task automatic drive_check(input bit rst, input bit fl, input bit iv,
                               input logic [31:0] d, input bit ordy);
        logic [31:0] ed;
        int unsigned ec;
        reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        #2;
        cur_rdy = exp_ready(ordy);
        if (m_known) begin
            ed = (mq.size() != 0) ? mq[0] : BUB;
            ec = m_cnt;
            chk("out_valid", out_valid, mq.size() != 0);
            chk("out_data", out_data, ed);
            chk("in_ready", in_ready, cur_rdy);
            chk("stall_cnt", stall_cnt, ec);
            chk("sat_out_data", sat_out_data, ed);
            chk("sat_in_ready", sat_in_ready, cur_rdy);
            chk("sat_cnt", sat_stall_cnt, (ec > 7) ? 7 : ec);
        end
        if (out_valid === 1'b1 && ordy) obs.push_back(out_data);
    endtask

    task automatic advance(input bit rst, input bit fl, input bit iv,
                           input logic [31:0] d, input bit ordy);
        bit pop;
        bit push;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            pop  = (mq.size() != 0) && ordy;
            push = iv && cur_rdy && !fl;
            if (mq.size() != 0 && !ordy && m_cnt < 65535) m_cnt++;
            if (fl) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(d);
            end
        end
        #1;
    endtask

    task automatic step(input bit rst, input bit fl, input bit iv,
                        input logic [31:0] d, input bit ordy);
        drive_check(rst, fl, iv, d, ordy);
        advance(rst, fl, iv, d, ordy);
    endtask

    typedef struct {
        bit          rst;
        bit          iv;
        logic [31:0] d;
        bit          ordy;
        bit          ev;
        logic [31:0] ed;
        bit          er;
        logic [15:0] ec;
    } vec_t;

    vec_t        tbl[11];
    logic [31:0] up[$];
    int unsigned cnt_before;

    initial begin
        // Reset then stream 1..8 at full rate; expectations identical in both builds
        tbl[0] = '{1'b1, 1'b1, 32'h77, 1'b0, 1'b0, BUB,   1'b1, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 32'h1,  1'b1, 1'b0, BUB,   1'b1, 16'd0};
        for (int k = 2; k <= 8; k++)
            tbl[k] = '{1'b0, 1'b1, 32'(k), 1'b1, 1'b1, 32'(k - 1), 1'b1, 16'd0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, BUB,   1'b1, 16'd0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        step(1'b1, 1'b0, 1'b1, 32'h99, 1'b1);
        for (int i = 0; i < 11; i++) begin
            drive_check(tbl[i].rst, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk("tbl_valid", out_valid, tbl[i].ev);
            chk("tbl_data", out_data, tbl[i].ed);
            chk("tbl_ready", in_ready, tbl[i].er);
            chk("tbl_cnt", stall_cnt, tbl[i].ec);
            advance(tbl[i].rst, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
        end

        // Backpressure: A, B, C offered while downstream stalls
        up = '{32'hA, 32'hB, 32'hC};
        obs.delete();
        for (int i = 0; i < 6; i++) begin
            bit acc;
            acc = (up.size() != 0) && exp_ready(1'b0);
            step(1'b0, 1'b0, up.size() != 0, (up.size() != 0) ? up[0] : 32'h0, 1'b0);
            if (acc) void'(up.pop_front());
        end
        chk("bp_cnt", stall_cnt, 16'd5);
        chk("bp_data", out_data, 32'hA);
        chk("bp_ready", in_ready, 1'b0);
        chk("bp_held", up.size(), SKID ? 1 : 2);
        for (int i = 0; i < 8; i++) begin
            bit acc;
            acc = (up.size() != 0) && exp_ready(1'b1);
            step(1'b0, 1'b0, up.size() != 0, (up.size() != 0) ? up[0] : 32'h0, 1'b1);
            if (acc) void'(up.pop_front());
        end
        chk("bp_order_n", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("bp_order0", obs[0], 32'hA);
            chk("bp_order1", obs[1], 32'hB);
            chk("bp_order2", obs[2], 32'hC);
        end

        // Flush with simultaneous push: 0x3 must never appear
        step(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
        cnt_before = m_cnt;
        chk("pre_fl_cnt", stall_cnt, 16'd6);
        step(1'b0, 1'b1, 1'b1, 32'h3, 1'b1);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_data", out_data, BUB);
        chk("fl_cnt", stall_cnt, cnt_before);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("fl_gone", out_valid, 1'b0);
        end

        // Saturation of the 3-bit counter
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sat_7", sat_stall_cnt, 3'd7);
        chk("cnt_10", stall_cnt, 16'd10);
        chk("sat_hold", out_data, 32'h5);

        // Reset in the middle of a stalled, filled stage
        step(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h23, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, BUB);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("rst_gone", out_valid, 1'b0);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 60) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
                 $urandom, ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
